// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// the hardwired-zero register index and the default counter width.
package hazard_control_unit_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO      = 5'd0;
    localparam int         DEFAULT_CNT_W = 16;

    // A load in EX whose destination feeds the instruction in ID; x0 never creates a dependency.
    function automatic logic is_load_use(input logic       mem_read,
                                         input logic [4:0] ex_rd,
                                         input logic [4:0] id_rs1,
                                         input logic [4:0] id_rs2);
        return mem_read && (ex_rd != REG_ZERO) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use bubbles, taken-branch flushes and
// memory-wait freezes, plus a sticky wait timeout and performance counters.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_RS1,
    input  logic [4:0]       IF_ID_RS2,
    input  logic [4:0]       ID_EX_RD,
    input  logic             ID_EX_MemRead,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] wait_count
);

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_next;
    logic             r_timeout;
    logic             w_load_use;
    logic             w_stall_inc;
    logic             w_flush_inc;
    logic             w_wait_inc;

    assign w_load_use  = is_load_use(ID_EX_MemRead, ID_EX_RD, IF_ID_RS1, IF_ID_RS2);
    assign mem_timeout = r_timeout;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        w_state_next = ST_RUN;
        w_timer_next = '0;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        w_wait_inc   = 1'b0;

        if (reset) begin
            {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write} = 4'b0000;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (((r_state == ST_MEM_WAIT) || mem_req) && !mem_ready) begin
            // Freeze everything; held branch/load-use inputs are serviced on the ready cycle.
            {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write} = 4'b0000;
            w_state_next = ST_MEM_WAIT;
            w_wait_inc   = 1'b1;
            if (r_state == ST_RUN) begin
                w_timer_next = CNT_W'(1);
            end else if (r_timer == TIMEOUT_V) begin
                w_timer_next = r_timer;
            end else begin
                w_timer_next = r_timer + 1'b1;
            end
        end else if (branch_taken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            w_flush_inc = 1'b1;
        end else if (w_load_use) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            w_stall_inc = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_timer   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            if (w_wait_inc && (w_timer_next == TIMEOUT_V)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_flush_inc),
        .count (flush_count)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_wait_inc),
        .count (wait_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit (TIMEOUT = 4).
module tb_hazard_control_unit;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       IF_ID_RS1, IF_ID_RS2, ID_EX_RD;
    logic             ID_EX_MemRead, branch_taken, mem_req, mem_ready;
    logic             PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
    logic             IF_ID_Flush, ID_EX_Flush, mem_timeout;
    logic [CNT_W-1:0] stall_count, flush_count, wait_count;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_control_unit #(.CNT_W(CNT_W), .TIMEOUT(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .IF_ID_RS1     (IF_ID_RS1),
        .IF_ID_RS2     (IF_ID_RS2),
        .ID_EX_RD      (ID_EX_RD),
        .ID_EX_MemRead (ID_EX_MemRead),
        .branch_taken  (branch_taken),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .PC_Write      (PC_Write),
        .IF_ID_Write   (IF_ID_Write),
        .ID_EX_Write   (ID_EX_Write),
        .EX_MEM_Write  (EX_MEM_Write),
        .IF_ID_Flush   (IF_ID_Flush),
        .ID_EX_Flush   (ID_EX_Flush),
        .mem_timeout   (mem_timeout),
        .stall_count   (stall_count),
        .flush_count   (flush_count),
        .wait_count    (wait_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Control vector order: PC, IF_ID_W, ID_EX_W, EX_MEM_W, IF_ID_Flush, ID_EX_Flush
    task automatic check_ctl(input string tag, input logic [5:0] expected);
        check(tag, 32'({PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, IF_ID_Flush, ID_EX_Flush}),
              32'(expected));
    endtask

    task automatic check_cnt(input string tag, input int s, input int f, input int w);
        check({tag, "_stall"}, 32'(stall_count), s);
        check({tag, "_flush"}, 32'(flush_count), f);
        check({tag, "_wait"},  32'(wait_count),  w);
    endtask

    task automatic idle();
        IF_ID_RS1 = 5'd1; IF_ID_RS2 = 5'd2; ID_EX_RD = 5'd3;
        ID_EX_MemRead = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #1 check_ctl("reset_ctl", 6'b000011);
        tick(); tick();
        reset = 1'b0;
        #1 check_ctl("idle_ctl", 6'b111100);
        check_cnt("after_reset", 0, 0, 0);
        check("after_reset_timeout", 32'(mem_timeout), 0);

        // Load with rd = x0 never stalls
        ID_EX_MemRead = 1'b1; ID_EX_RD = 5'd0; IF_ID_RS1 = 5'd0;
        #1 check_ctl("x0_load_ctl", 6'b111100);
        tick(); idle();
        check("x0_load_stall", 32'(stall_count), 0);

        // Load-use through rs2: one bubble
        ID_EX_MemRead = 1'b1; ID_EX_RD = 5'd5; IF_ID_RS2 = 5'd5;
        #1 check_ctl("load_use_ctl", 6'b001101);
        tick(); idle();
        #1 check_ctl("after_load_use_ctl", 6'b111100);
        check("load_use_stall", 32'(stall_count), 1);

        // Branch with coincident load-use: branch wins
        branch_taken = 1'b1; ID_EX_MemRead = 1'b1; ID_EX_RD = 5'd7; IF_ID_RS1 = 5'd7;
        #1 check_ctl("branch_lu_ctl", 6'b111111);
        tick(); idle();
        check_cnt("branch_lu", 1, 1, 0);

        // Zero-wait access
        mem_req = 1'b1; mem_ready = 1'b1;
        #1 check_ctl("zero_wait_ctl", 6'b111100);
        tick(); idle();
        check("zero_wait_count", 32'(wait_count), 0);

        // Three-cycle memory wait
        mem_req = 1'b1; mem_ready = 1'b0;
        #1 check_ctl("wait1_ctl", 6'b000000);
        tick();
        check_ctl("wait2_ctl", 6'b000000);
        tick();
        check_ctl("wait3_ctl", 6'b000000);
        tick();
        mem_ready = 1'b1;
        #1 check_ctl("wait_ready_ctl", 6'b111100);
        check("wait_count_3", 32'(wait_count), 3);
        tick(); idle();
        check("wait_count_hold", 32'(wait_count), 3);
        check("no_timeout_3", 32'(mem_timeout), 0);

        // Branch held during a wait is serviced on the ready cycle
        mem_req = 1'b1; branch_taken = 1'b1;
        #1 check_ctl("held_br_wait_ctl", 6'b000000);
        tick();
        check_ctl("held_br_wait2_ctl", 6'b000000);
        tick();
        mem_ready = 1'b1;
        #1 check_ctl("held_br_ready_ctl", 6'b111111);
        tick(); idle();
        check_cnt("held_br", 1, 2, 5);

        // Timeout after the 4th wait cycle, sticky after ready
        mem_req = 1'b1;
        tick(); tick(); tick();
        check("timeout_before", 32'(mem_timeout), 0);
        tick();
        check("timeout_rise", 32'(mem_timeout), 1);
        tick(); tick();
        check_ctl("timeout_still_wait_ctl", 6'b000000);
        mem_ready = 1'b1;
        #1 check_ctl("timeout_ready_ctl", 6'b111100);
        tick(); idle();
        check("timeout_sticky", 32'(mem_timeout), 1);
        check("timeout_wait_count", 32'(wait_count), 11);

        // Reset while in MEM_WAIT
        mem_req = 1'b1;
        tick();
        mem_req = 1'b0;
        #1 check_ctl("midwait_ctl", 6'b000000);
        reset = 1'b1;
        #1 check_ctl("midwait_reset_ctl", 6'b000011);
        tick();
        reset = 1'b0;
        #1 check_ctl("post_reset_ctl", 6'b111100);
        check_cnt("post_reset", 0, 0, 0);
        check("post_reset_timeout", 32'(mem_timeout), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
